// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: hunts for a sync word, shifts one frame per CLB
// into shadow storage, verifies an XOR checksum and commits the image atomically.
module clb_cfg_loader #(
    parameter int unsigned NUM_CLB   = 4,
    parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_din,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_abort,
    output logic [16*NUM_CLB-1:0] cfg_lut_mem,
    output logic [NUM_CLB-1:0]    cfg_sel_ff,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_error
);

    localparam int unsigned LUT_W     = 16;
    localparam int unsigned FRAME_W   = LUT_W + 1;
    localparam int unsigned LOAD_BITS = FRAME_W * NUM_CLB;
    localparam int unsigned CNT_W     = $clog2(LOAD_BITS + 1);
    localparam int unsigned FBIT_W    = $clog2(FRAME_W);
    localparam int unsigned MEM_W     = LUT_W * NUM_CLB;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    state_e               state_q,   state_d;
    logic [LUT_W-1:0]     hunt_q,    hunt_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [FBIT_W-1:0]    fbit_q,    fbit_d;
    logic [LUT_W-1:0]     xor_q,     xor_d;
    logic [LUT_W-1:0]     csum_q,    csum_d;
    logic [LOAD_BITS-1:0] shadow_q,  shadow_d;
    logic [MEM_W-1:0]     lut_mem_q, lut_mem_d;
    logic [NUM_CLB-1:0]   sel_ff_q,  sel_ff_d;
    logic                 busy_q,    busy_d;
    logic                 ready_q,   ready_d;
    logic                 done_q,    done_d;
    logic                 error_q,   error_d;

    logic [LUT_W-1:0]     hunt_shift;
    logic [LUT_W-1:0]     csum_shift;
    logic [MEM_W-1:0]     shadow_lut;
    logic [NUM_CLB-1:0]   shadow_sel;

    // Frame 0 arrives first, so it ends up at the top of the shadow shift register
    always_comb begin
        shadow_lut = '0;
        shadow_sel = '0;
        for (int unsigned k = 0; k < NUM_CLB; k++) begin
            shadow_lut[LUT_W*k +: LUT_W] = shadow_q[LOAD_BITS-1-FRAME_W*k -: LUT_W];
            shadow_sel[k]                = shadow_q[LOAD_BITS-FRAME_W-FRAME_W*k];
        end
    end

    // Next-state and datapath updates; abort wins over bit acceptance and commit
    always_comb begin
        state_d    = state_q;
        hunt_d     = hunt_q;
        cnt_d      = cnt_q;
        fbit_d     = fbit_q;
        xor_d      = xor_q;
        csum_d     = csum_q;
        shadow_d   = shadow_q;
        lut_mem_d  = lut_mem_q;
        sel_ff_d   = sel_ff_q;
        done_d     = done_q;
        error_d    = error_q;
        hunt_shift = {hunt_q[LUT_W-2:0], cfg_din};
        csum_shift = {csum_q[LUT_W-2:0], cfg_din};

        unique case (state_q)
            ST_SYNC: begin
                if (cfg_abort) begin
                    hunt_d = '0;
                end else if (cfg_valid) begin
                    hunt_d = hunt_shift;
                    if (hunt_shift == SYNC_WORD) begin
                        state_d = ST_LOAD;
                        hunt_d  = '0;
                        cnt_d   = '0;
                        fbit_d  = '0;
                        xor_d   = '0;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_d = ST_SYNC;
                    hunt_d  = '0;
                end else if (cfg_valid) begin
                    shadow_d = {shadow_q[LOAD_BITS-2:0], cfg_din};
                    if (fbit_q == FBIT_W'(LUT_W - 1)) begin
                        xor_d = xor_q ^ {shadow_q[LUT_W-2:0], cfg_din};
                    end
                    fbit_d = (fbit_q == FBIT_W'(FRAME_W - 1)) ? '0 : fbit_q + FBIT_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LOAD_BITS - 1)) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CHECK: begin
                if (cfg_abort) begin
                    state_d = ST_SYNC;
                    hunt_d  = '0;
                end else if (cfg_valid) begin
                    csum_d = csum_shift;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LUT_W - 1)) begin
                        cnt_d = '0;
                        if (csum_shift == xor_q) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d = ST_SYNC;
                            hunt_d  = '0;
                            error_d = 1'b1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_SYNC;
                hunt_d  = '0;
                if (!cfg_abort) begin
                    lut_mem_d = shadow_lut;
                    sel_ff_d  = shadow_sel;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_SYNC;
                hunt_d  = '0;
            end
        endcase

        busy_d  = (state_d != ST_SYNC);
        ready_d = (state_d != ST_COMMIT);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            hunt_q    <= '0;
            cnt_q     <= '0;
            fbit_q    <= '0;
            xor_q     <= '0;
            csum_q    <= '0;
            shadow_q  <= '0;
            lut_mem_q <= '0;
            sel_ff_q  <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hunt_q    <= hunt_d;
            cnt_q     <= cnt_d;
            fbit_q    <= fbit_d;
            xor_q     <= xor_d;
            csum_q    <= csum_d;
            shadow_q  <= shadow_d;
            lut_mem_q <= lut_mem_d;
            sel_ff_q  <= sel_ff_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign cfg_busy    = busy_q;
    assign cfg_done    = done_q;
    assign cfg_error   = error_q;
    assign cfg_lut_mem = lut_mem_q;
    assign cfg_sel_ff  = sel_ff_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader with NUM_CLB=2: stimulus pushes the
// reference-model outcome of each load; a monitor pops it when busy drops.
module tb_clb_cfg_loader;

    localparam int unsigned N = 2;
    localparam logic [15:0] SYNC = 16'hA5C3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_din = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic            cfg_abort = 1'b0;
    logic [16*N-1:0] cfg_lut_mem;
    logic [N-1:0]    cfg_sel_ff;
    logic            cfg_busy;
    logic            cfg_done;
    logic            cfg_error;

    clb_cfg_loader #(.NUM_CLB(N), .SYNC_WORD(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_din    (cfg_din),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_abort  (cfg_abort),
        .cfg_lut_mem(cfg_lut_mem),
        .cfg_sel_ff (cfg_sel_ff),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic        err;
        logic [31:0] lut;
        logic [1:0]  sel;
        int          rl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   gap_en   = 1'b0;

    // Reference model of the externally visible configuration state
    logic [31:0] m_lut  = '0;
    logic [1:0]  m_sel  = '0;
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t snapshot(input int rl);
        exp_t e;
        e.done = m_done;
        e.err  = m_err;
        e.lut  = m_lut;
        e.sel  = m_sel;
        e.rl   = rl;
        return e;
    endfunction

    // Monitor: each busy high->low transition closes one load attempt
    logic busy_p = 1'b0;
    int   rl_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cfg_busy && !cfg_ready) rl_cnt++;
            if (busy_p && !cfg_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end_of_load", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done",      32'(cfg_done),    32'(e.done));
                    check("sb_error",     32'(cfg_error),   32'(e.err));
                    check("sb_lut_mem",   cfg_lut_mem,      e.lut);
                    check("sb_sel_ff",    32'(cfg_sel_ff),  32'(e.sel));
                    check("sb_ready_low", 32'(rl_cnt),      32'(e.rl));
                end
                rl_cnt = 0;
            end
            busy_p = cfg_busy;
        end
    end

    // Offer one bit and hold it until the loader is ready; it transfers on the next rising edge
    task automatic send_bit(input logic b, input bit chk_busy);
        bit acc;
        @(negedge clk);
        if (chk_busy) check("busy_after_sync", 32'(cfg_busy), 32'(1));
        if (gap_en) begin
            while ($urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b0;
                @(negedge clk);
            end
        end
        cfg_valid = 1'b1;
        cfg_din   = b;
        acc       = cfg_ready;
        while (!acc) begin
            @(negedge clk);
            acc = cfg_ready;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
    endtask

    task automatic send_stream(input logic [15:0] l0, input logic [15:0] l1,
                               input logic s0, input logic s1, input logic [15:0] csum);
        logic [15:0] lw;
        logic        sw;
        send_word(SYNC);
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lw = (k == 0) ? l0 : l1;
            sw = (k == 0) ? s0 : s1;
            for (int i = 15; i >= 0; i--) send_bit(lw[i], (k == 0) && (i == 15));
            send_bit(sw, 1'b0);
        end
        send_word(csum);
        if (csum == (l0 ^ l1)) begin
            m_lut  = {l1, l0};
            m_sel  = {s1, s0};
            m_done = 1'b1;
            exp_q.push_back(snapshot(1));
        end else begin
            m_err = 1'b1;
            exp_q.push_back(snapshot(0));
        end
    endtask

    initial begin
        logic [15:0] l0, l1, cs;
        logic        s0, s1;

        // Reset values
        #12;
        check("rst_lut",   cfg_lut_mem,      32'h0);
        check("rst_sel",   32'(cfg_sel_ff),  32'(0));
        check("rst_done",  32'(cfg_done),    32'(0));
        check("rst_error", 32'(cfg_error),   32'(0));
        check("rst_busy",  32'(cfg_busy),    32'(0));
        check("rst_ready", 32'(cfg_ready),   32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Bad checksum right after reset: error set, outputs stay zero
        send_stream(16'h8000, 16'h6996, 1'b0, 1'b1, 16'hE997);
        idle(1);
        check("bad_error_edge", 32'(cfg_error), 32'(1));
        check("bad_busy_edge",  32'(cfg_busy),  32'(0));
        check("bad_lut_kept",   cfg_lut_mem,    32'h0);
        idle(3);

        // Good stream back-to-back, commit timing
        send_stream(16'h8000, 16'h6996, 1'b0, 1'b1, 16'hE996);
        idle(1);
        check("commit_ready_low", 32'(cfg_ready), 32'(0));
        check("commit_busy",      32'(cfg_busy),  32'(1));
        check("commit_done_pre",  32'(cfg_done),  32'(0));
        idle(1);
        check("commit_done",  32'(cfg_done),   32'(1));
        check("commit_ready", 32'(cfg_ready),  32'(1));
        check("commit_lut",   cfg_lut_mem,     32'h6996_8000);
        check("commit_sel",   32'(cfg_sel_ff), 32'(2'b10));
        idle(3);

        // Noise and a near-miss sync must not start a load
        send_word(16'h5A5A);
        send_word(16'hA5C2);
        send_stream(16'h8000, 16'h6996, 1'b0, 1'b1, 16'hE996);
        idle(4);

        // Same stream with random valid gaps
        gap_en = 1'b1;
        send_stream(16'h8000, 16'h6996, 1'b0, 1'b1, 16'hE996);
        gap_en = 1'b0;
        idle(4);
        check("gap_lut", cfg_lut_mem, 32'h6996_8000);

        // Abort mid-frame 1, then a fresh stream
        send_word(SYNC);
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int i = 0; i < 17 + 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        exp_q.push_back(snapshot(0));
        @(negedge clk);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_din   = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        idle(2);
        send_stream(16'hFFFE, 16'h0001, 1'b1, 1'b0, 16'hFFFF);
        idle(4);
        check("abort_then_lut", cfg_lut_mem, 32'h0001_FFFE);

        // Random streams, some with corrupted checksums
        for (int r = 0; r < 10; r++) begin
            l0 = 16'($urandom());
            l1 = 16'($urandom());
            s0 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1));
            cs = l0 ^ l1;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 16'($urandom_range(1, 65535));
            gap_en = ($urandom_range(0, 1) == 1);
            send_stream(l0, l1, s0, s1, cs);
            gap_en = 1'b0;
            idle(3);
        end

        // Commit, then reset in the middle of the next load
        send_stream(16'h8000, 16'h6996, 1'b0, 1'b1, 16'hE996);
        idle(4);
        send_word(SYNC);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        m_lut  = '0;
        m_sel  = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        exp_q.push_back(snapshot(0));
        #2;
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_lut",   cfg_lut_mem,     32'h0);
        check("midrst_sel",   32'(cfg_sel_ff), 32'(0));
        check("midrst_done",  32'(cfg_done),   32'(0));
        check("midrst_busy",  32'(cfg_busy),   32'(0));
        check("midrst_ready", 32'(cfg_ready),  32'(1));
        idle(3);
        rst_n = 1'b1;
        idle(3);
        check("postrst_busy", 32'(cfg_busy), 32'(0));
        send_stream(16'h8000, 16'h6996, 1'b0, 1'b1, 16'hE996);
        idle(4);
        check("postrst_lut", cfg_lut_mem, 32'h6996_8000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
